// File: rtl/jk_exc_counter_pkg.sv
// jk_exc_counter_pkg: shared JK excitation/characteristic functions and default sizing.
// Contents: DEF_WIDTH, DEF_MODULUS, jk_t, excite(q, n) -> {j, k}, jk_next(j, k, q) -> q+.
package jk_exc_counter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MODULUS = 10;
  typedef struct packed {
    logic j;
    logic k;
  } jk_t;
  // Don't-care excitation terms resolve to 0, so J and K are never both set.
  function automatic jk_t excite(input logic q, input logic n);
    return '{j: ~q & n, k: q & ~n};
  endfunction
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction
endpackage

// File: rtl/jk_exc_counter_jk.sv
// jk_cell: single JK flip-flop bit with synchronous active-high clear.
// Ports: clk clock, rst sync clear, j_i/k_i excitation, q_o stored bit.
module jk_cell
  import jk_exc_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);
  logic q_q, q_d;
  assign q_d = rst ? 1'b0 : jk_next(j_i, k_i, q_q);
  always_ff @(posedge clk) q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/jk_exc_counter.sv
// jk_exc_counter: modulo up/down counter whose state lives only in JK cells.
// Ports: CLK clock, R sync reset, E count enable, UP direction, LD/DIN parallel load,
// Q count, TC terminal count, JV/KV per-bit J/K excitation this cycle.
// Macro JK_EXC_COUNTER_LOAD_EN enables LD/DIN; otherwise they are ignored.
module jk_exc_counter
  import jk_exc_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             E,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic [WIDTH-1:0] JV,
  output logic [WIDTH-1:0] KV
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0] MOD_X = (WIDTH + 1)'(MODULUS);
  logic [WIDTH-1:0] q, n, j, k, up_nxt, dn_nxt, cnt, ld_val;
  logic ld, oor;
`ifdef JK_EXC_COUNTER_LOAD_EN
  assign ld = LD;
  assign ld_val = ({1'b0, DIN} < MOD_X) ? DIN : MAXV;
`else
  logic unused_ld;
  assign ld = 1'b0;
  assign ld_val = q;
  assign unused_ld = ^{LD, DIN};
`endif
  assign oor = {1'b0, q} >= MOD_X;
  assign up_nxt = (q == MAXV) ? '0 : q + 1'b1;
  assign dn_nxt = (q == '0) ? MAXV : q - 1'b1;
  assign cnt = oor ? '0 : (UP ? up_nxt : dn_nxt);
  // Reset drives N = 0, which makes the excitation show the clear pattern (J = 0, K = Q).
  assign n = R ? '0 : ld ? ld_val : E ? cnt : q;
  assign TC = ~R & ~ld & E & (UP ? (q == MAXV) : (q == '0));
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_t x;
    assign x = excite(q[i], n[i]);
    assign j[i] = x.j;
    assign k[i] = x.k;
    jk_cell u_cell (
      .clk(CLK),
      .rst(R),
      .j_i(j[i]),
      .k_i(k[i]),
      .q_o(q[i])
    );
  end
  assign Q = q;
  assign JV = j;
  assign KV = k;
endmodule

// File: tb/tb_jk_exc_counter.sv
// tb_jk_exc_counter: directed scoreboard bench for jk_exc_counter (WIDTH 4, MODULUS 10).
module tb_jk_exc_counter;
`ifdef JK_EXC_COUNTER_LOAD_EN
  localparam bit LDEN = 1'b1;
`else
  localparam bit LDEN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic R, E, UP, LD, TC;
  logic [3:0] DIN, Q, JV, KV;
  int checks = 0, errors = 0, mq = 0;
  logic [3:0] sb[$];

  jk_exc_counter dut (
    .CLK(CLK), .R(R), .E(E), .UP(UP), .LD(LD), .DIN(DIN),
    .Q(Q), .TC(TC), .JV(JV), .KV(KV)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_n(int q, bit r, bit e, bit up, bit ld, int din);
    if (r) return 0;
    if (LDEN && ld) return (din < 10) ? din : 9;
    if (e) begin
      if (q >= 10) return 0;
      if (up) return (q == 9) ? 0 : q + 1;
      return (q == 0) ? 9 : q - 1;
    end
    return q;
  endfunction

  task automatic step(input string tag, input bit r, input bit e, input bit up,
                      input bit ld, input int din);
    int n;
    logic [3:0] qv, nv;
    logic tc;
    R = r; E = e; UP = up; LD = ld; DIN = 4'(din);
    #1;
    n = model_n(mq, r, e, up, ld, din);
    qv = 4'(mq);
    nv = 4'(n);
    tc = !r && !(LDEN && ld) && e && (up ? (mq == 9) : (mq == 0));
    chk({tag, "_tc"}, {3'b0, TC}, {3'b0, tc});
    chk({tag, "_jv"}, JV, ~qv & nv);
    chk({tag, "_kv"}, KV, qv & ~nv);
    chk({tag, "_jk_excl"}, JV & KV, 4'h0);
    sb.push_back(nv);
    @(posedge CLK);
    #1;
    nv = sb.pop_front();
    chk({tag, "_q"}, Q, nv);
    mq = int'(nv);
  endtask

  initial begin
    R = 1'b1; E = 1'b0; UP = 1'b1; LD = 1'b0; DIN = 4'h0;
    @(posedge CLK);
    #1;
    chk("por_q", Q, 4'h0);
    chk("por_tc", {3'b0, TC}, 4'h0);
    mq = 0;
    step("idle", 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step("to7", 0, 1, 1, 0, 0);
    chk("at7", Q, 4'h7);
    R = 1'b1; E = 1'b1; #1;
    chk("rst_jv", JV, 4'h0);
    chk("rst_kv", KV, 4'h7);
    chk("rst_tc", {3'b0, TC}, 4'h0);
    step("rst_mid", 1, 1, 1, 0, 0);
    chk("rst_q", Q, 4'h0);
    for (int i = 0; i < 12; i++) step("up12", 0, 1, 1, 0, 0);
    chk("up12_end", Q, 4'h2);
    step("dn_to1", 0, 1, 0, 0, 0);
    chk("dn_at1", Q, 4'h1);
    UP = 1'b0; E = 1'b1; #1;
    chk("dn10_jv", JV, 4'h0);
    chk("dn10_kv", KV, 4'h1);
    step("dn_1_0", 0, 1, 0, 0, 0);
    step("dn_0_9", 0, 1, 0, 0, 0);
    chk("dn_wrap", Q, 4'h9);
    step("hold", 0, 0, 0, 0, 0);
    step("dn_to5", 0, 1, 0, 0, 0);
    step("dn_to5", 0, 1, 0, 0, 0);
    step("dn_to5", 0, 1, 0, 0, 0);
    step("dn_to5", 0, 1, 0, 0, 0);
    chk("at5", Q, 4'h5);
    step("ld13", 0, 1, 1, 1, 13);
    chk("ld13_q", Q, LDEN ? 4'h9 : 4'h6);
    step("ld3", 0, 0, 1, 1, 3);
    step("updn", 0, 1, 0, 0, 0);
    step("updn", 0, 1, 1, 0, 0);
    step("rst", 1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step("to7b", 0, 1, 1, 0, 0);
    UP = 1'b1; E = 1'b1; #1;
    chk("7to8_jv", JV, 4'h8);
    chk("7to8_kv", KV, 4'h7);
    step("7to8", 0, 1, 1, 0, 0);
    chk("7to8_q", Q, 4'h8);
    step("rst_ld", 1, 1, 1, 1, 5);
    chk("rst_ld_q", Q, 4'h0);
    step("rel_hold", 0, 0, 1, 0, 0);
    chk("rel_hold_q", Q, 4'h0);
    step("first_up", 0, 1, 1, 0, 0);
    chk("first_up_q", Q, 4'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
